alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single registered ALU between two requesters: requester 0 is the CPU execute stage and requester 1 is a secondary engine such as a block-copy or checksum unit. It arbitrates round-robin, registers the operation into the ALU and returns result plus flags to the owner. Each requester keeps its own carry/flag context, so an ADDC/SUBC chain on one requester is never corrupted by the other.

Parameters:
DATA_WIDTH, 32, operand/result width; must match the ALU.
OP_WIDTH, 5, ALU opcode width.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
reqN_valid  in  1  request present, N=0,1
reqN_ready  out  1  request accepted this cycle when valid&ready
reqN_op  in  OP_WIDTH  ALU opcode (shared opcode constants)
reqN_a  in  DATA_WIDTH  first operand (ALU reg2)
reqN_b  in  DATA_WIDTH  second operand (ALU reg3)
rspN_valid  out  1  one-cycle pulse: result for requester N
rspN_result  out  DATA_WIDTH  ALU result
rspN_flags  out  4  {over, neg, zero, carry}
alu_op  out  OP_WIDTH  to ALU op
alu_reg2, alu_reg3  out  DATA_WIDTH  to ALU operands
alu_carry_in  out  1  to ALU carry_in
alu_result  in  DATA_WIDTH  from ALU
alu_carry, alu_zero, alu_neg, alu_over  in  1  from ALU flag outputs

Behaviour:
- Pipeline stages:
  - Issue stage S1: registered alu_op/alu_reg2/alu_reg3/alu_carry_in, plus s1_valid and s1_id.
  - Result stage S2: s2_valid and s2_id, shifted from S1 each cycle. The ALU registers internally between S1 and S2.
- Latency: a request accepted in cycle N drives the ALU inputs in N+1. The ALU output and rspN_valid appear in N+2.
- rspN_result and rspN_flags are combinational from the ALU outputs. They are meaningful only while rspN_valid=1.
- Throughput: one accept per cycle overall.
- Busy rule: busyN = s1_valid & (s1_id==N). A requester is never granted while busy.
  - Same requester: at most one accept every 2 cycles (accept N, ready low N+1, ready may be high N+2).
  - Two alternating requesters fill the ALU every cycle.
- Eligibility: eligN = reqN_valid & ~busyN.
- Grant: if exactly one requester is eligible, it is granted.
  - If both are eligible, the requester opposite last_grant wins. last_grant updates only on an accept.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Ready: reqN_ready = ~busyN & (no competing eligible requester, or N holds priority). readyN never depends on reqN_valid.
- Flag context: per-requester registers flagsN[3:0] are loaded from the ALU outputs in every cycle that rspN_valid=1. All op types update them, including COMP/BIT/TEST.
- Carry selection: alu_carry_in for an issued op is the owner's carry.
  - If the owner's previous op is returning in the same cycle (s2_valid & s2_id==N), alu_carry from the ALU is bypassed in.
  - Otherwise flagsN[0] is used.
  - This bypass covers the back-to-back ADDC case (accept at N+2).
- Compare/test ops: the result is the ALU's pass-through value. The arbiter does not alter it.
- Idle cycles: the ALU inputs hold their last values. s1_valid=0 so nothing is returned; whatever the ALU computes is ignored.
- Reset:
  - All valid bits, flags0, flags1 and alu_carry_in are cleared to 0; alu_op, alu_reg2 and alu_reg3 are cleared to 0.
  - reqN_ready is 0 during reset.
  - In-flight operations are discarded and produce no rsp pulse, including reset asserted mid-operation.
- Simultaneous events: an accept and a response for different requesters in the same cycle are independent. An accept and a response for the same requester in the same cycle uses the bypass.

Decomposition:
- Opcode constants (OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, …) stay in the existing shared ALU header.
- A new shared header adds flag bit indices FLAG_CARRY=0, FLAG_ZERO=1, FLAG_NEG=2, FLAG_OVER=3 and requester IDs REQ_CPU=0, REQ_AUX=1.
- Sub-module alu_rr_arbiter2: 2-way round-robin grant from elig0/elig1 and last_grant.
- The top level instantiates the existing ALU inside the testbench only, not inside this block.

Test Plan:
1. req0 ADD a=0xFFFFFFFF b=0x00000001 accepted cycle N -> rsp0_valid at N+2 only, rsp0_result=0x00000000, rsp0_flags=4'b0011; rsp1_valid stays 0.
2. req0 ADDC a=0 b=0 offered at N+1 after test 1 -> ready0=0 in N+1, accept N+2 with bypassed carry=1, rsp0_result=0x00000001 at N+4.
3. Both valid continuously with ADD ops -> grants alternate 0,1,0,1 starting with 0; one rsp every cycle from N+2; no request ever dropped or duplicated.
4. Context isolation: req0 ADD 0xFFFFFFFF+1 (carry=1) interleaved with req1 ADDC 5+5 (req1 carry=0) -> rsp1_result=0x0000000A; a following req0 ADDC 0+0 -> 0x00000001.
5. req1 COMP a=3 b=5 -> rsp1_result=0x00000003, flags neg=1, carry=1, zero=0.
6. Assert reset in the cycle after accepting a req1 op -> no rsp1_valid ever appears, both readys low during reset, flags0 and flags1 read 0 on the next op.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU opcodes, flag bit indices and requester ids
package alu_arbiter_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDC = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SUBC = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_COMP = 5'd7;
    localparam logic [4:0] OP_TEST = 5'd8;
    localparam logic [4:0] OP_BIT  = 5'd9;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_OVER  = 3;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_AUX = 1'b1
    } req_id_t;

    function automatic logic [3:0] pack_flags(input logic over, input logic neg,
                                              input logic zero, input logic carry);
        return {over, neg, zero, carry};
    endfunction

endpackage

// File: rtl/alu_rr_arbiter2.sv
// rtl/alu_rr_arbiter2.sv - two-way round-robin grant; last_grant=1 means requester 1 won last
module alu_rr_arbiter2 (
    input  logic elig0,
    input  logic elig1,
    input  logic last_grant,
    output logic prio0,
    output logic prio1,
    output logic grant0,
    output logic grant1
);

    // prio is independent of the requester's own eligibility so ready never depends on valid
    always_comb begin
        prio0  = ~elig1 | last_grant;
        prio1  = ~elig0 | ~last_grant;
        grant0 = elig0 & prio0;
        grant1 = elig1 & prio1;
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one registered ALU between two requesters with per-requester flag context
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [OP_WIDTH-1:0]   req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_result,
    output logic [3:0]            rsp0_flags,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_result,
    output logic [3:0]            rsp1_flags,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] alu_reg2,
    output logic [DATA_WIDTH-1:0] alu_reg3,
    output logic                  alu_carry_in,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_carry,
    input  logic                  alu_zero,
    input  logic                  alu_neg,
    input  logic                  alu_over
);

    logic    s1_valid;
    req_id_t s1_id;
    logic    s2_valid;
    req_id_t s2_id;
    logic    last_grant;
    logic [3:0] flags0;
    logic [3:0] flags1;

    logic busy0, busy1, elig0, elig1;
    logic prio0, prio1, grant0, grant1;
    logic accept0, accept1;
    logic ret0, ret1;
    logic carry0, carry1;
    logic [3:0] alu_flags;

    always_comb begin
        busy0 = s1_valid & (s1_id == REQ_CPU);
        busy1 = s1_valid & (s1_id == REQ_AUX);
        elig0 = req0_valid & ~busy0;
        elig1 = req1_valid & ~busy1;
    end

    alu_rr_arbiter2 u_rr (
        .elig0      (elig0),
        .elig1      (elig1),
        .last_grant (last_grant),
        .prio0      (prio0),
        .prio1      (prio1),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    always_comb begin
        req0_ready = ~reset & ~busy0 & prio0;
        req1_ready = ~reset & ~busy1 & prio1;
        accept0    = grant0 & ~reset;
        accept1    = grant1 & ~reset;
        alu_flags  = pack_flags(alu_over, alu_neg, alu_zero, alu_carry);
        ret0       = s2_valid & (s2_id == REQ_CPU);
        ret1       = s2_valid & (s2_id == REQ_AUX);
        // a same-requester op returning this cycle hasn't reached flagsN yet
        carry0     = ret0 ? alu_carry : flags0[FLAG_CARRY];
        carry1     = ret1 ? alu_carry : flags1[FLAG_CARRY];
        rsp0_valid = ret0 & ~reset;
        rsp1_valid = ret1 & ~reset;
        rsp0_result = alu_result;
        rsp1_result = alu_result;
        rsp0_flags  = alu_flags;
        rsp1_flags  = alu_flags;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_id        <= REQ_CPU;
            s2_valid     <= 1'b0;
            s2_id        <= REQ_CPU;
            last_grant   <= 1'b1;
            flags0       <= '0;
            flags1       <= '0;
            alu_op       <= '0;
            alu_reg2     <= '0;
            alu_reg3     <= '0;
            alu_carry_in <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            s1_valid <= accept0 | accept1;
            if (accept0) begin
                s1_id        <= REQ_CPU;
                alu_op       <= req0_op;
                alu_reg2     <= req0_a;
                alu_reg3     <= req0_b;
                alu_carry_in <= carry0;
                last_grant   <= 1'b0;
            end else if (accept1) begin
                s1_id        <= REQ_AUX;
                alu_op       <= req1_op;
                alu_reg2     <= req1_a;
                alu_reg3     <= req1_b;
                alu_carry_in <= carry1;
                last_grant   <= 1'b1;
            end
            if (rsp0_valid) flags0 <= alu_flags;
            if (rsp1_valid) flags1 <= alu_flags;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a registered ALU model
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;
    logic [3:0]  rsp0_flags, rsp1_flags;
    logic [4:0]  alu_op;
    logic [31:0] alu_reg2, alu_reg3;
    logic        alu_carry_in;
    logic [31:0] alu_result;
    logic [3:0]  alu_f;

    alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(5)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
        .alu_op(alu_op), .alu_reg2(alu_reg2), .alu_reg3(alu_reg3), .alu_carry_in(alu_carry_in),
        .alu_result(alu_result), .alu_carry(alu_f[0]), .alu_zero(alu_f[1]),
        .alu_neg(alu_f[2]), .alu_over(alu_f[3])
    );

    // returns {over, neg, zero, carry, result}; carry on subtraction means borrow
    function automatic logic [35:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        logic [32:0] w;
        logic [31:0] r, t;
        logic c, v;
        w = '0; r = a; t = a; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD, OP_ADDC: begin
                w = {1'b0, a} + {1'b0, b} + ((op == OP_ADDC) ? {32'd0, cin} : 33'd0);
                t = w[31:0]; r = t; c = w[32];
                v = (a[31] == b[31]) && (t[31] != a[31]);
            end
            OP_SUB, OP_SUBC, OP_COMP: begin
                w = {1'b0, a} - {1'b0, b} - ((op == OP_SUBC) ? {32'd0, cin} : 33'd0);
                t = w[31:0]; c = w[32];
                r = (op == OP_COMP) ? a : t;
                v = (a[31] != b[31]) && (t[31] != a[31]);
            end
            OP_AND:  begin t = a & b; r = t; end
            OP_OR:   begin t = a | b; r = t; end
            OP_XOR:  begin t = a ^ b; r = t; end
            OP_TEST: t = a & b;
            OP_BIT:  t = a & (32'd1 << b[4:0]);
            default: t = a;
        endcase
        return {v, t[31], (t == 32'd0), c, r};
    endfunction

    // the shared ALU: registered, no reset
    always @(posedge clock) begin
        {alu_f, alu_result} <= ref_alu(alu_op, alu_reg2, alu_reg3, alu_carry_in);
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int total = 0;
    int bad = 0;
    int cnt0 = 0, cnt1 = 0;
    logic [31:0] lr0_result, lr1_result;
    logic [3:0]  lr0_flags, lr1_flags;
    int          lr0_cyc, lr1_cyc;

    // reference state: per-requester context in program order, plus arbitration history
    logic [3:0] ctx0, ctx1;
    logic [1:0] busy_m;
    logic       last_m;
    logic       rst_next;
    logic       act_r0, act_r1, gr0, gr1;
    int         drv_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_rsp(input int id, input logic v, input logic [31:0] res,
                             input logic [3:0] fl);
        exp_t e;
        if (id == 0) begin
            while (q0.size() > 0 && q0[0].due < cyc) begin
                chk("rsp0_missing", 64'(q0[0].due), 64'(cyc));
                void'(q0.pop_front());
            end
            if (v) begin
                cnt0++; lr0_result = res; lr0_flags = fl; lr0_cyc = cyc;
                if (q0.size() == 0) chk("rsp0_unexpected", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("rsp0_result", 64'(res), 64'(e.result));
                    chk("rsp0_flags", 64'(fl), 64'(e.flags));
                    chk("rsp0_latency", 64'(cyc), 64'(e.due));
                end
            end
        end else begin
            while (q1.size() > 0 && q1[0].due < cyc) begin
                chk("rsp1_missing", 64'(q1[0].due), 64'(cyc));
                void'(q1.pop_front());
            end
            if (v) begin
                cnt1++; lr1_result = res; lr1_flags = fl; lr1_cyc = cyc;
                if (q1.size() == 0) chk("rsp1_unexpected", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("rsp1_result", 64'(res), 64'(e.result));
                    chk("rsp1_flags", 64'(fl), 64'(e.flags));
                    chk("rsp1_latency", 64'(cyc), 64'(e.due));
                end
            end
        end
    endtask

    always begin
        @(negedge clock);
        #1;
        check_rsp(0, rsp0_valid, rsp0_result, rsp0_flags);
        check_rsp(1, rsp1_valid, rsp1_result, rsp1_flags);
    end

    task automatic cycle(input logic v0, input logic [4:0] o0, input logic [31:0] a0,
                         input logic [31:0] b0, input logic v1, input logic [4:0] o1,
                         input logic [31:0] a1, input logic [31:0] b1);
        logic e0, e1, er0, er1;
        logic [35:0] m;
        exp_t x;
        @(negedge clock);
        reset = rst_next;
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        drv_cyc = cyc;
        if (reset) begin
            q0.delete(); q1.delete();
            ctx0 = '0; ctx1 = '0; last_m = 1'b1;
        end
        #2;
        e0 = v0 && !busy_m[0];
        e1 = v1 && !busy_m[1];
        er0 = !reset && !busy_m[0] && (!e1 || last_m);
        er1 = !reset && !busy_m[1] && (!e0 || !last_m);
        act_r0 = req0_ready;
        act_r1 = req1_ready;
        chk("ready0", 64'(act_r0), 64'(er0));
        chk("ready1", 64'(act_r1), 64'(er1));
        gr0 = v0 && er0;
        gr1 = v1 && er1;
        if (gr0) begin
            m = ref_alu(o0, a0, b0, ctx0[FLAG_CARRY]);
            x.result = m[31:0]; x.flags = m[35:32]; x.due = drv_cyc + 2;
            q0.push_back(x); ctx0 = m[35:32]; last_m = 1'b0;
        end
        if (gr1) begin
            m = ref_alu(o1, a1, b1, ctx1[FLAG_CARRY]);
            x.result = m[31:0]; x.flags = m[35:32]; x.due = drv_cyc + 2;
            q1.push_back(x); ctx1 = m[35:32]; last_m = 1'b1;
        end
        busy_m = {gr1, gr0};
        @(posedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send(input int id, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        int n = 0;
        logic got;
        do begin
            if (id == 0) cycle(1, op, a, b, 0, 0, 0, 0);
            else         cycle(0, 0, 0, 0, 1, op, a, b);
            got = (id == 0) ? gr0 : gr1;
            n++;
        end while (!got && n < 4);
        chk("send_accepted", 64'(got), 1);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0] ops [10];
        int t1, c1;
        ops = '{OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_COMP, OP_TEST, OP_BIT};
        reset = 1'b1; rst_next = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        ctx0 = 0; ctx1 = 0; busy_m = 0; last_m = 1;
        lr0_result = 0; lr1_result = 0; lr0_flags = 0; lr1_flags = 0; lr0_cyc = 0; lr1_cyc = 0;

        idle(3);
        chk("reset_ready0", 64'(req0_ready), 0);
        chk("reset_ready1", 64'(req1_ready), 0);
        rst_next = 1'b0;
        idle(1);
        chk("reset_alu_op", 64'(alu_op), 0);
        chk("reset_alu_reg2", 64'(alu_reg2), 0);
        chk("reset_alu_reg3", 64'(alu_reg3), 0);
        chk("reset_alu_carry_in", 64'(alu_carry_in), 0);

        // ADD wrap, then back-to-back ADDC relying on the carry bypass
        cycle(1, OP_ADD, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0);
        t1 = drv_cyc;
        cycle(1, OP_ADDC, 0, 0, 0, 0, 0, 0);
        chk("t2_ready0_busy", 64'(act_r0), 0);
        cycle(1, OP_ADDC, 0, 0, 0, 0, 0, 0);
        chk("t2_accept", 64'(act_r0), 1);
        chk("t1_result", 64'(lr0_result), 0);
        chk("t1_flags", 64'(lr0_flags), 64'(4'b0011));
        chk("t1_latency", 64'(lr0_cyc), 64'(t1 + 2));
        chk("t1_no_rsp1", 64'(cnt1), 0);
        idle(2);
        chk("t2_result", 64'(lr0_result), 1);
        chk("t2_latency", 64'(lr0_cyc), 64'(t1 + 4));

        // carry contexts stay separate
        cycle(1, OP_ADD, 32'hFFFF_FFFF, 32'h1, 1, OP_ADDC, 32'd5, 32'd5);
        if (!gr0) send(0, OP_ADD, 32'hFFFF_FFFF, 32'h1);
        if (!gr1) send(1, OP_ADDC, 32'd5, 32'd5);
        send(0, OP_ADDC, 0, 0);
        idle(3);
        chk("t4_rsp1_result", 64'(lr1_result), 64'h0000_000A);
        chk("t4_rsp0_result", 64'(lr0_result), 64'h0000_0001);

        send(1, OP_COMP, 32'd3, 32'd5);
        idle(3);
        chk("t5_result", 64'(lr1_result), 64'h3);
        chk("t5_flags", 64'(lr1_flags), 64'(4'b0101));

        // reset with operations in flight in both stages
        send(0, OP_ADD, 32'hFFFF_FFFF, 32'h1);
        send(1, OP_ADD, 32'h1, 32'h1);
        c1 = cnt1;
        rst_next = 1'b1;
        idle(2);
        chk("t6_ready0_reset", 64'(act_r0), 0);
        chk("t6_ready1_reset", 64'(act_r1), 0);
        rst_next = 1'b0;
        idle(4);
        chk("t6_no_rsp1", 64'(cnt1), 64'(c1));
        send(0, OP_ADDC, 0, 0);
        send(1, OP_ADDC, 0, 0);
        idle(3);
        chk("t6_flags0_cleared", 64'(lr0_result), 0);
        chk("t6_flags1_cleared", 64'(lr1_result), 0);
        chk("t6_flags1_value", 64'(lr1_flags), 64'(4'b0010));

        // both requesters continuously valid: grants alternate starting with 0
        for (int i = 0; i < 8; i++) begin
            cycle(1, OP_ADD, $urandom, $urandom, 1, OP_ADD, $urandom, $urandom);
            chk("t3_accept0", 64'(act_r0), 64'((i % 2) == 0));
            chk("t3_accept1", 64'(act_r1), 64'((i % 2) == 1));
        end
        idle(3);

        for (int i = 0; i < 500; i++) begin
            rst_next = ($urandom_range(0, 149) == 0);
            cycle($urandom_range(0, 9) < 7, ops[$urandom_range(0, 9)], rnd_opnd(), rnd_opnd(),
                  $urandom_range(0, 9) < 7, ops[$urandom_range(0, 9)], rnd_opnd(), rnd_opnd());
        end
        rst_next = 1'b0;
        idle(4);
        chk("drain_q0", 64'(q0.size()), 0);
        chk("drain_q1", 64'(q1.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
